// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//
// UART transmitter with a valid/ready byte input and a small transmit buffer.
// Bytes are queued, then serialised LSB first onto data_tx. Each frame is a
// start bit, 5..8 data bits, an optional parity bit and one or two stop bits.
// The frame format and the baud divisor are latched when a byte is popped, so
// changing them only affects later frames.
//
// Build option:
//   UART_TX_FIFO_EN defined   : FIFO_DEPTH-entry circular buffer.
//   UART_TX_FIFO_EN undefined : single holding register (depth 1); FIFO_DEPTH
//                               only sets the fifo_count port width.
//
// Ports:
//   clock        system clock, all state on the rising edge
//   reset        asynchronous, active-high reset
//   baud_div     bit period is baud_div+1 clocks
//   data_len     00=5, 01=6, 10=7, 11=8 data bits
//   parity_type  00=none, 01=odd, 10=even, 11=none
//   stop_bits    0=one, 1=two stop bits
//   tx_data      byte to queue
//   tx_valid     producer offers tx_data
//   tx_ready     buffer not full
//   data_tx      serial line, idles high
//   active_flag  high while a frame is on the line
//   done_flag    one-cycle pulse after the last stop bit
//   fifo_count   number of occupied buffer entries
module uart_tx_fifo #(
   parameter int FIFO_DEPTH = 8,
   parameter int DIV_WIDTH  = 16
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [DIV_WIDTH-1:0]        baud_div,
   input  logic [1:0]                  data_len,
   input  logic [1:0]                  parity_type,
   input  logic                        stop_bits,
   input  logic [7:0]                  tx_data,
   input  logic                        tx_valid,
   output logic                        tx_ready,
   output logic                        data_tx,
   output logic                        active_flag,
   output logic                        done_flag,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   logic [CW-1:0]        count_q, count_d;
   logic                 ready_q, ready_d;
   logic                 push, pop, load;
   logic [7:0]           head;

   logic [2:0]           state_q, state_d;
   logic [DIV_WIDTH-1:0] div_q, div_d;
   logic [DIV_WIDTH-1:0] baud_cnt_q, baud_cnt_d;
   logic [2:0]           bit_cnt_q, bit_cnt_d;
   logic [1:0]           len_q, len_d;
   logic [1:0]           par_q, par_d;
   logic                 stop_q, stop_d;
   logic [7:0]           data_q, data_d;
   logic                 tx_q, tx_d;
   logic                 active_q, active_d;
   logic                 done_q, done_d;
   logic                 bit_end;

   // Bits above the selected length are cleared at load time so they can
   // never reach the line or the parity bit.
   function automatic logic [7:0] len_mask(input logic [1:0] l);
      case (l)
         2'b00:   len_mask = 8'h1F;
         2'b01:   len_mask = 8'h3F;
         2'b10:   len_mask = 8'h7F;
         default: len_mask = 8'hFF;
      endcase
   endfunction

   assign push = tx_valid && ready_q;

   // ---------------------------------------------------------------- buffer
`ifdef UART_TX_FIFO_EN
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;

   assign head = mem_q[rd_ptr_q];

   // Pointers wrap naturally because the depth is a power of two.
   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push) mem_q[wr_ptr_q] <= tx_data;
   end
`else
   localparam logic [CW-1:0] FULL = CW'(1);

   logic [7:0] hold_q, hold_d;

   assign head = hold_q;

   always_comb hold_d = push ? tx_data : hold_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) hold_q <= '0;
      else       hold_q <= hold_d;
   end
`endif

   // Push and pop on the same edge leave the count unchanged.
   always_comb begin
      count_d = count_q;
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
      ready_d = (count_d != FULL);
   end

   // ------------------------------------------------------------------- FSM
   assign bit_end = (baud_cnt_q == div_q);

   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      len_d      = len_q;
      par_d      = par_q;
      stop_d     = stop_q;
      data_d     = data_q;
      baud_cnt_d = baud_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      done_d     = 1'b0;
      load       = 1'b0;
      pop        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (count_q != '0) load = 1'b1;
         end
         S_START: begin
            if (bit_end) begin
               state_d    = S_DATA;
               baud_cnt_d = '0;
               bit_cnt_d  = '0;
            end else begin
               baud_cnt_d = baud_cnt_q + DIV_WIDTH'(1);
            end
         end
         S_DATA: begin
            if (bit_end) begin
               baud_cnt_d = '0;
               // last data bit index is N-1 = data_len + 4
               if (bit_cnt_q == ({1'b0, len_q} + 3'd4)) begin
                  bit_cnt_d = '0;
                  state_d   = (par_q == 2'b01 || par_q == 2'b10) ? S_PARITY : S_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end else begin
               baud_cnt_d = baud_cnt_q + DIV_WIDTH'(1);
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               state_d    = S_STOP;
               baud_cnt_d = '0;
               bit_cnt_d  = '0;
            end else begin
               baud_cnt_d = baud_cnt_q + DIV_WIDTH'(1);
            end
         end
         S_STOP: begin
            if (bit_end) begin
               baud_cnt_d = '0;
               if (bit_cnt_q == {2'b00, stop_q}) begin
                  done_d = 1'b1;
                  // chain straight into the next start bit when data waits
                  if (count_q != '0) load = 1'b1;
                  else               state_d = S_IDLE;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end else begin
               baud_cnt_d = baud_cnt_q + DIV_WIDTH'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (load) begin
         pop        = 1'b1;
         state_d    = S_START;
         div_d      = baud_div;
         len_d      = data_len;
         par_d      = parity_type;
         stop_d     = stop_bits;
         data_d     = head & len_mask(data_len);
         baud_cnt_d = '0;
         bit_cnt_d  = '0;
      end

      // Line level is registered: derive it from the next state.
      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = data_d[bit_cnt_d];
         S_PARITY: tx_d = (^data_d) ^ (par_d == 2'b01);
         default:  tx_d = 1'b1;
      endcase
      active_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         div_q      <= '0;
         len_q      <= '0;
         par_q      <= '0;
         stop_q     <= 1'b0;
         data_q     <= '0;
         baud_cnt_q <= '0;
         bit_cnt_q  <= '0;
         count_q    <= '0;
         ready_q    <= 1'b1;
         tx_q       <= 1'b1;
         active_q   <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         len_q      <= len_d;
         par_q      <= par_d;
         stop_q     <= stop_d;
         data_q     <= data_d;
         baud_cnt_q <= baud_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         count_q    <= count_d;
         ready_q    <= ready_d;
         tx_q       <= tx_d;
         active_q   <= active_d;
         done_q     <= done_d;
      end
   end

   assign tx_ready    = ready_q;
   assign data_tx     = tx_q;
   assign active_flag = active_q;
   assign done_flag   = done_q;
   assign fifo_count  = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo. Works with or without UART_TX_FIFO_EN.
module tb_uart_tx_fifo;

`ifdef UART_TX_FIFO_EN
   localparam int DEPTH = 8;
`else
   localparam int DEPTH = 1;
`endif
   localparam int CW = 4;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [15:0]   baud_div = 16'd3;
   logic [1:0]    data_len = 2'b11;
   logic [1:0]    parity_type = 2'b00;
   logic          stop_bits = 1'b0;
   logic [7:0]    tx_data = 8'h00;
   logic          tx_valid = 1'b0;
   logic          tx_ready, data_tx, active_flag, done_flag;
   logic [CW-1:0] fifo_count;

   int checks = 0;
   int failures = 0;
   int done_total = 0;
   int contig = 0;

   // expected frame: data byte plus the format it must be sent with
   typedef struct {
      logic [7:0] data;
      int         div;
      int         len;
      int         par;   // 0 none, 1 odd, 2 even
      int         stop;  // 1 or 2
   } frame_t;

   frame_t sb[$];
   int cur_len = 8, cur_par = 0, cur_stop = 1;

   uart_tx_fifo #(.FIFO_DEPTH(8), .DIV_WIDTH(16)) dut (
      .clock(clock), .reset(reset), .baud_div(baud_div), .data_len(data_len),
      .parity_type(parity_type), .stop_bits(stop_bits), .tx_data(tx_data),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .data_tx(data_tx),
      .active_flag(active_flag), .done_flag(done_flag), .fifo_count(fifo_count)
   );

   always #5 clock = ~clock;

   always @(negedge clock) if (done_flag === 1'b1) done_total++;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------- model
   task automatic build_frame(input frame_t f, output logic [11:0] bits, output int nb);
      logic p;
      p = 1'b0;
      bits = '1;
      bits[0] = 1'b0;
      nb = 1;
      for (int k = 0; k < f.len; k++) begin
         bits[nb] = f.data[k];
         p ^= f.data[k];
         nb++;
      end
      if (f.par == 1) begin bits[nb] = ~p; nb++; end
      else if (f.par == 2) begin bits[nb] = p; nb++; end
      nb += f.stop;
   endtask

   // -------------------------------------------------------------- monitor
   task automatic mon_frames();
      frame_t f;
      logic [11:0] bits;
      int nb, per;
      bit more;
      more = 1'b1;
      while (more) begin
         if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_frame: data_tx went low with nothing queued (t=%0t)", $time);
            while (active_flag === 1'b1 && !reset) @(negedge clock);
            return;
         end
         f = sb.pop_front();
         build_frame(f, bits, nb);
         per = f.div + 1;
         for (int i = 0; i < nb * per; i++) begin
            if (i > 0) begin
               @(negedge clock);
               if (reset) return;
            end
            checks++;
            if (data_tx !== bits[i / per] || active_flag !== 1'b1 ||
                (i > 0 && done_flag !== 1'b0)) begin
               failures++;
               $display("FAIL frame_bit: byte %02h cycle %0d got tx=%b act=%b done=%b, want tx=%b act=1 done=0",
                        f.data, i, data_tx, active_flag, done_flag, bits[i / per]);
            end
         end
         @(negedge clock);
         if (reset) return;
         checks++;
         if (done_flag !== 1'b1) begin
            failures++;
            $display("FAIL done_pulse: byte %02h done_flag=%b after last stop bit, want 1", f.data, done_flag);
         end
         more = (data_tx === 1'b0);
         if (more) contig++;
         else begin
            checks++;
            if (active_flag !== 1'b0) begin
               failures++;
               $display("FAIL active_fall: active_flag=%b after final frame, want 0", active_flag);
            end
         end
      end
   endtask

   initial forever begin
      @(negedge clock);
      if (!reset && data_tx === 1'b0) mon_frames();
   end

   // ---------------------------------------------------------- stimulus
   task automatic set_cfg(input int div, input int len, input int par, input int stop);
      baud_div    = 16'(div);
      data_len    = 2'(len - 5);
      parity_type = (par == 1) ? 2'b01 : (par == 2) ? 2'b10 : 2'b00;
      stop_bits   = (stop == 2);
      cur_len = len; cur_par = par; cur_stop = stop;
   endtask

   // called and returns at posedge+1
   task automatic push(input logic [7:0] d, input int exp_div);
      frame_t f;
      int w;
      tx_data = d;
      tx_valid = 1'b1;
      w = 0;
      while (tx_ready !== 1'b1 && w < 3000) begin
         @(posedge clock); #1; w++;
      end
      if (w >= 3000) begin
         checks++; failures++;
         $display("FAIL push_timeout: tx_ready stayed %b for byte %02h", tx_ready, d);
         tx_valid = 1'b0;
         return;
      end
      f.data = d; f.div = exp_div; f.len = cur_len; f.par = cur_par; f.stop = cur_stop;
      sb.push_back(f);
      @(posedge clock); #1;
      tx_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int w;
      w = 0;
      while ((sb.size() != 0 || active_flag !== 1'b0 || fifo_count !== '0) && w < 5000) begin
         @(posedge clock); #1; w++;
      end
      checks++;
      if (w >= 5000) begin
         failures++;
         $display("FAIL %s_idle: still busy after %0d cycles, queued=%0d active=%b", name, w, sb.size(), active_flag);
      end
      repeat (2) @(posedge clock);
      #1;
   endtask

   // cycles from first start-bit sample to the done pulse, and line level
   // sampled at the first cycle of each bit period
   task automatic measure_frame(input int per, output int cyc, output logic [11:0] line);
      int w, t;
      line = '1;
      cyc = -1;
      w = 0;
      @(negedge clock);
      while (data_tx !== 1'b0 && w < 500) begin @(negedge clock); w++; end
      if (w >= 500) return;
      t = 0;
      while (done_flag !== 1'b1 && t < 500) begin
         if (t % per == 0 && t / per < 12) line[t / per] = data_tx;
         @(negedge clock); t++;
      end
      if (t < 500) cyc = t;
   endtask

   // -------------------------------------------------------------- tests
   task automatic test_reset();
      repeat (2) @(posedge clock);
      #1;
      checks++;
      if (data_tx !== 1'b1 || active_flag !== 1'b0 || done_flag !== 1'b0) begin
         failures++;
         $display("FAIL reset_line: tx=%b act=%b done=%b, want 1 0 0", data_tx, active_flag, done_flag);
      end
      checks++;
      if (tx_ready !== 1'b1 || fifo_count !== '0) begin
         failures++;
         $display("FAIL reset_buffer: ready=%b count=%0d, want 1 0", tx_ready, fifo_count);
      end
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
   endtask

   task automatic test_latency();
      frame_t f;
      int d0;
      d0 = done_total;
      set_cfg(3, 8, 0, 1);
      tx_data = 8'h3C; tx_valid = 1'b1;
      f.data = 8'h3C; f.div = 3; f.len = 8; f.par = 0; f.stop = 1;
      sb.push_back(f);
      @(posedge clock); #1;
      tx_valid = 1'b0;
      checks++;
      if (fifo_count !== CW'(1) || data_tx !== 1'b1 || tx_ready !== (DEPTH > 1)) begin
         failures++;
         $display("FAIL latency_push: count=%0d tx=%b ready=%b, want 1 1 %0d", fifo_count, data_tx, tx_ready, DEPTH > 1);
      end
      @(posedge clock); #1;
      checks++;
      if (fifo_count !== '0 || data_tx !== 1'b0 || active_flag !== 1'b1 || tx_ready !== 1'b1) begin
         failures++;
         $display("FAIL latency_pop: count=%0d tx=%b act=%b ready=%b, want 0 0 1 1", fifo_count, data_tx, active_flag, tx_ready);
      end
      wait_idle("latency");
      checks++;
      if (done_total - d0 !== 1) begin
         failures++;
         $display("FAIL latency_done: %0d pulses, want 1", done_total - d0);
      end
   endtask

   task automatic test_8n1();
      int cyc, d0;
      logic [11:0] line;
      d0 = done_total;
      set_cfg(3, 8, 0, 1);
      push(8'hA5, 3);
      measure_frame(4, cyc, line);
      checks++;
      if (cyc !== 40) begin
         failures++; $display("FAIL 8n1_len: %0d cycles to done, want 40", cyc);
      end
      checks++;
      if (line[9:0] !== 10'b1101001010) begin
         failures++; $display("FAIL 8n1_line: %b, want 1101001010 (bit0 right)", line[9:0]);
      end
      wait_idle("8n1");
      checks++;
      if (done_total - d0 !== 1) begin
         failures++; $display("FAIL 8n1_done: %0d pulses, want 1", done_total - d0);
      end
   endtask

   task automatic test_parity();
      int cyc;
      logic [11:0] line;
      set_cfg(3, 8, 2, 1);
      push(8'hA5, 3);
      measure_frame(4, cyc, line);
      checks++;
      if (line[9] !== 1'b0 || cyc !== 44) begin
         failures++; $display("FAIL 8e1: parity=%b len=%0d, want 0 44", line[9], cyc);
      end
      wait_idle("8e1");
      set_cfg(3, 8, 1, 1);
      push(8'hA5, 3);
      measure_frame(4, cyc, line);
      checks++;
      if (line[9] !== 1'b1 || cyc !== 44) begin
         failures++; $display("FAIL 8o1: parity=%b len=%0d, want 1 44", line[9], cyc);
      end
      wait_idle("8o1");
      set_cfg(3, 7, 2, 2);
      push(8'h55, 3);
      measure_frame(4, cyc, line);
      checks++;
      if (line[10:0] !== 11'b11010101010 || cyc !== 44) begin
         failures++; $display("FAIL 7e2: line=%b len=%0d, want 11010101010 44", line[10:0], cyc);
      end
      wait_idle("7e2");
   endtask

   task automatic test_5n1();
      int cyc;
      logic [11:0] line;
      set_cfg(0, 5, 0, 1);
      push(8'hFF, 0);
      measure_frame(1, cyc, line);
      checks++;
      if (line[6:0] !== 7'b1111110 || cyc !== 7) begin
         failures++; $display("FAIL 5n1: line=%b len=%0d, want 1111110 7", line[6:0], cyc);
      end
      wait_idle("5n1");
   endtask

   task automatic test_back_to_back();
      int d0, c0;
      d0 = done_total;
      c0 = contig;
      set_cfg(1, 8, 0, 1);
      for (int i = 0; i <= DEPTH; i++) push(8'(i * 37 + 3), 1);
      checks++;
      if (fifo_count !== CW'(DEPTH) || tx_ready !== 1'b0) begin
         failures++;
         $display("FAIL b2b_full: count=%0d ready=%b, want %0d 0", fifo_count, tx_ready, DEPTH);
      end
      for (int i = DEPTH + 1; i < 10; i++) push(8'(i * 37 + 3), 1);
      wait_idle("b2b");
      checks++;
      if (done_total - d0 !== 10) begin
         failures++; $display("FAIL b2b_done: %0d pulses, want 10", done_total - d0);
      end
      checks++;
      if (contig - c0 !== 9) begin
         failures++; $display("FAIL b2b_gapless: %0d chained frames, want 9", contig - c0);
      end
   endtask

   task automatic test_baud_change();
      int d0, c0;
      d0 = done_total;
      c0 = contig;
      set_cfg(3, 8, 0, 1);
      push(8'h5A, 3);
      push(8'hC3, 7);
      repeat (6) @(posedge clock);
      #1;
      baud_div = 16'd7;
      wait_idle("baud");
      checks++;
      if (done_total - d0 !== 2 || contig - c0 !== 1) begin
         failures++;
         $display("FAIL baud_frames: done=%0d chained=%0d, want 2 1", done_total - d0, contig - c0);
      end
      baud_div = 16'd3;
   endtask

   task automatic test_reset_mid();
      int w, d0;
      bit quiet;
      set_cfg(3, 8, 0, 1);
      push(8'h11, 3);
      push(8'h22, 3);
      push(8'h33, 3);
      w = 0;
      while (sb.size() > 1 && w < 3000) begin @(posedge clock); #1; w++; end
      repeat (8) @(posedge clock);
      #1;
      reset = 1'b1;
      #1;
      checks++;
      if (data_tx !== 1'b1 || fifo_count !== '0 || active_flag !== 1'b0 ||
          tx_ready !== 1'b1 || done_flag !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid: tx=%b count=%0d act=%b ready=%b done=%b, want 1 0 0 1 0",
                  data_tx, fifo_count, active_flag, tx_ready, done_flag);
      end
      sb.delete();
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      d0 = done_total;
      quiet = 1'b1;
      repeat (60) begin
         @(negedge clock);
         if (data_tx !== 1'b1 || active_flag !== 1'b0) quiet = 1'b0;
      end
      checks++;
      if (!quiet || done_total != d0) begin
         failures++; $display("FAIL reset_residual: line activity after reset, done pulses=%0d", done_total - d0);
      end
      @(posedge clock); #1;
      push(8'h96, 3);
      wait_idle("after_reset");
      checks++;
      if (done_total - d0 !== 1) begin
         failures++; $display("FAIL after_reset_done: %0d pulses, want 1", done_total - d0);
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_8n1();
      test_parity();
      test_5n1();
      test_back_to_back();
      test_baud_change();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
